sent_tx_pulse_gen_param: RTL and testbench

Parametrised SENT transmit pulse generator. It converts a stream of symbol commands into the SENT line waveform on `data_pulse`, with configurable tick counts.

- Symbol commands are SYNC, DATA nibble and PAUSE.
- A one-deep holding register lets symbols run back-to-back.
- Frame-length accounting makes PAUSE pad each frame to a constant length.
- Sits between the frame sequencer (CRC/nibble packing) and the TX pin driver. Clocked by the tick clock.

---
 rtl/sent_tx_pkg.sv | 29 ++
 rtl/sent_tx_sym_len.sv | 57 +++++
 rtl/sent_tx_pulse_gen_param.sv | 134 +++++++++++++
 tb/tb_sent_tx_pulse_gen_param.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sent_tx_pkg.sv
// Shared definitions for the SENT transmit pulse generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sent_tx_pkg;

    // Symbol command encoding on sym_type
    typedef enum logic [1:0] {
        SYM_SYNC  = 2'd0,
        SYM_DATA  = 2'd1,
        SYM_PAUSE = 2'd2,
        SYM_RSVD  = 2'd3
    } sym_type_e;

    // Default tick counts
    localparam int DEF_LOW_TICKS   = 5;
    localparam int DEF_SYNC_TICKS  = 56;
    localparam int DEF_DATA_BASE   = 12;
    localparam int DEF_FRAME_TICKS = 282;
    localparam int DEF_PAUSE_MIN   = 12;
    localparam int DEF_CNT_W       = 10;

    // Line state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sent_tx_sym_len.sv
// Symbol length / PAUSE clamp calculator: (type, nibble, acc, mode) -> len, overrun.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever the holding register is loaded.
module sent_tx_sym_len
    import sent_tx_pkg::*;
#(
    parameter int SYNC_TICKS  = DEF_SYNC_TICKS,
    parameter int DATA_BASE   = DEF_DATA_BASE,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int PAUSE_MIN   = DEF_PAUSE_MIN,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic [1:0]       sym_type,
    input  logic [3:0]       sym_nibble,
    input  logic [CNT_W-1:0] acc,
    input  logic             fixed_frame,
    input  logic [CNT_W-1:0] pause_len,
    output logic [CNT_W-1:0] len,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] PMIN  = CNT_W'(PAUSE_MIN);
    localparam logic [CNT_W-1:0] FRAME = CNT_W'(FRAME_TICKS);

    logic [CNT_W-1:0] remain;

    always_comb begin
        len     = '0;
        overrun = 1'b0;
        remain  = '0;
        case (sym_type_e'(sym_type))
            SYM_SYNC: len = CNT_W'(SYNC_TICKS);
            SYM_DATA: len = CNT_W'(DATA_BASE) + CNT_W'(sym_nibble);
            SYM_PAUSE: begin
                if (fixed_frame) begin
                    // Range check first so the unsigned subtraction never wraps
                    if (acc >= FRAME) begin
                        len     = PMIN;
                        overrun = 1'b1;
                    end else begin
                        remain = FRAME - acc;
                        if (remain < PMIN) begin
                            len     = PMIN;
                            overrun = 1'b1;
                        end else begin
                            len = remain;
                        end
                    end
                end else begin
                    len = (pause_len < PMIN) ? PMIN : pause_len;
                end
            end
            default: len = '0;  // reserved: never loaded
        endcase
    end

endmodule

// File: rtl/sent_tx_pulse_gen_param.sv
// SENT TX pulse generator: symbol commands in, SENT line waveform out on data_pulse.
// Latency: command accepted in IDLE at edge k drives the line low from edge k+1.
// Backpressure: sym_ready = holding register empty; a held symbol starts right after pulse_done.
// Ports: ticks/reset_tx_n clock+reset; fixed_frame/pause_len PAUSE mode; sym_* command
// handshake; busy/pulse_done/frame_overrun/illegal_sym status; data_pulse line (idle high).
module sent_tx_pulse_gen_param
    import sent_tx_pkg::*;
#(
    parameter int LOW_TICKS   = DEF_LOW_TICKS,
    parameter int SYNC_TICKS  = DEF_SYNC_TICKS,
    parameter int DATA_BASE   = DEF_DATA_BASE,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int PAUSE_MIN   = DEF_PAUSE_MIN,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             ticks,
    input  logic             reset_tx_n,
    input  logic             fixed_frame,
    input  logic [CNT_W-1:0] pause_len,
    input  logic             sym_valid,
    input  logic [1:0]       sym_type,
    input  logic [3:0]       sym_nibble,
    output logic             sym_ready,
    output logic             busy,
    output logic             pulse_done,
    output logic             frame_overrun,
    output logic             illegal_sym,
    output logic             data_pulse
);

    logic             hold_full;
    logic [1:0]       hold_type;
    logic [3:0]       hold_nibble;
    tx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] acc;

    logic [CNT_W-1:0] calc_len;
    logic             calc_ovr;
    logic [CNT_W:0]   data_sum;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             load;

    assign sym_ready = ~hold_full;
    assign accept    = sym_valid & ~hold_full;
    // Load from IDLE, or on the last tick of the running symbol for zero-gap chaining
    assign load      = hold_full & ((state == IDLE) | pulse_done);
    assign data_sum  = {1'b0, acc} + {1'b0, calc_len};
    assign cnt_next  = cnt + 1'b1;

    sent_tx_sym_len #(
        .SYNC_TICKS  (SYNC_TICKS),
        .DATA_BASE   (DATA_BASE),
        .FRAME_TICKS (FRAME_TICKS),
        .PAUSE_MIN   (PAUSE_MIN),
        .CNT_W       (CNT_W)
    ) u_sym_len (
        .sym_type    (hold_type),
        .sym_nibble  (hold_nibble),
        .acc         (acc),
        .fixed_frame (fixed_frame),
        .pause_len   (pause_len),
        .len         (calc_len),
        .overrun     (calc_ovr)
    );

    // Holding register; accept and load are mutually exclusive (accept needs it empty)
    always_ff @(posedge ticks or negedge reset_tx_n) begin
        if (!reset_tx_n) begin
            hold_full   <= 1'b0;
            hold_type   <= 2'd0;
            hold_nibble <= 4'd0;
            illegal_sym <= 1'b0;
        end else begin
            illegal_sym <= accept && (sym_type == SYM_RSVD);
            if (accept && (sym_type != SYM_RSVD)) begin
                hold_full   <= 1'b1;
                hold_type   <= sym_type;
                hold_nibble <= sym_nibble;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

    // Line FSM; cnt is the 1-based tick index within the current symbol
    always_ff @(posedge ticks or negedge reset_tx_n) begin
        if (!reset_tx_n) begin
            state         <= IDLE;
            cnt           <= '0;
            len_q         <= '0;
            acc           <= '0;
            data_pulse    <= 1'b1;
            busy          <= 1'b0;
            pulse_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= 1'b0;
            if (load) begin
                state         <= LOW;
                cnt           <= CNT_W'(1);
                len_q         <= calc_len;
                data_pulse    <= 1'b0;
                busy          <= 1'b1;
                pulse_done    <= 1'b0;
                frame_overrun <= calc_ovr;
                case (sym_type_e'(hold_type))
                    SYM_SYNC:  acc <= CNT_W'(SYNC_TICKS);
                    SYM_DATA:  acc <= data_sum[CNT_W] ? '1 : data_sum[CNT_W-1:0];
                    SYM_PAUSE: acc <= '0;
                    default:   acc <= acc;
                endcase
            end else if (state != IDLE) begin
                if (pulse_done) begin
                    state      <= IDLE;
                    cnt        <= '0;
                    data_pulse <= 1'b1;
                    busy       <= 1'b0;
                    pulse_done <= 1'b0;
                end else begin
                    cnt        <= cnt_next;
                    pulse_done <= (cnt_next == len_q);
                    if (cnt_next > CNT_W'(LOW_TICKS)) begin
                        state      <= HIGH;
                        data_pulse <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sent_tx_pulse_gen_param.sv
// Bench for sent_tx_pulse_gen_param: directed + randomized symbol streams against a
// queue-based waveform model built from the symbol length / frame accounting rules.
// Every cycle the line, busy, strobes and sym_ready are compared with the model.
module tb_sent_tx_pulse_gen_param;

    localparam int CNT_W = 10;
    localparam int LOWT  = 5;
    localparam int SYNCT = 56;
    localparam int DBASE = 12;
    localparam int FRAME = 282;
    localparam int PMIN  = 12;
    localparam int ACC_MAX = (1 << CNT_W) - 1;

    logic             ticks = 1'b0;
    logic             reset_tx_n;
    logic             fixed_frame;
    logic [CNT_W-1:0] pause_len;
    logic             sym_valid;
    logic [1:0]       sym_type;
    logic [3:0]       sym_nibble;
    logic             sym_ready, busy, pulse_done, frame_overrun, illegal_sym, data_pulse;

    always #5 ticks = ~ticks;

    sent_tx_pulse_gen_param #(
        .LOW_TICKS(LOWT), .SYNC_TICKS(SYNCT), .DATA_BASE(DBASE),
        .FRAME_TICKS(FRAME), .PAUSE_MIN(PMIN), .CNT_W(CNT_W)
    ) dut (
        .ticks(ticks), .reset_tx_n(reset_tx_n), .fixed_frame(fixed_frame),
        .pause_len(pause_len), .sym_valid(sym_valid), .sym_type(sym_type),
        .sym_nibble(sym_nibble), .sym_ready(sym_ready), .busy(busy),
        .pulse_done(pulse_done), .frame_overrun(frame_overrun),
        .illegal_sym(illegal_sym), .data_pulse(data_pulse)
    );

    typedef struct { int len; bit ovr; } sym_t;

    int   checks = 0;
    int   failures = 0;
    sym_t q[$];           // accepted symbols not yet on the line
    int   m_acc = 0;
    bit   m_active = 0;
    int   m_pos = 0;
    int   m_len = 0;
    bit   m_ovr = 0;
    bit   m_ill = 0;
    bit   last_acc = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    // Expected length of a symbol from the frame-accounting rules, in acceptance order
    function automatic sym_t model_len(input int t, input int nib);
        sym_t s;
        s.ovr = 1'b0;
        s.len = 0;
        if (t == 0) begin
            s.len = SYNCT;
            m_acc = SYNCT;
        end else if (t == 1) begin
            s.len = DBASE + nib;
            m_acc = (m_acc + s.len > ACC_MAX) ? ACC_MAX : m_acc + s.len;
        end else begin
            if (fixed_frame) begin
                if (m_acc >= FRAME || FRAME - m_acc < PMIN) begin
                    s.len = PMIN;
                    s.ovr = 1'b1;
                end else begin
                    s.len = FRAME - m_acc;
                end
            end else begin
                s.len = (int'(pause_len) < PMIN) ? PMIN : int'(pause_len);
            end
            m_acc = 0;
        end
        return s;
    endfunction

    // One clock: advance the model, record any handshake, compare all outputs
    task automatic cycle();
        bit   acc_now;
        int   ct, cn;
        sym_t s;
        acc_now = sym_valid && sym_ready;
        ct = int'(sym_type);
        cn = int'(sym_nibble);
        @(posedge ticks);
        #1;
        if (m_active && m_pos < m_len) begin
            m_pos++;
        end else begin
            m_active = 1'b0;
            if (q.size() > 0) begin
                s = q.pop_front();
                m_active = 1'b1;
                m_pos = 1;
                m_len = s.len;
                m_ovr = s.ovr;
            end
        end
        m_ill = 1'b0;
        if (acc_now) begin
            if (ct == 3) m_ill = 1'b1;
            else q.push_back(model_len(ct, cn));
        end
        last_acc = acc_now;
        chk("data_pulse",    data_pulse,    m_active ? (m_pos > LOWT) : 1'b1);
        chk("busy",          busy,          m_active);
        chk("pulse_done",    pulse_done,    m_active && (m_pos == m_len));
        chk("frame_overrun", frame_overrun, m_active && (m_pos == 1) && m_ovr);
        chk("illegal_sym",   illegal_sym,   m_ill);
        chk("sym_ready",     sym_ready,     q.size() == 0);
    endtask

    // Present a command (optionally after a gap with valid low) and wait for its handshake.
    // sym_valid is left high so consecutive sends exercise continuous valid.
    task automatic send(input int t, input int nib, input int gap);
        int n;
        if (gap > 0) begin
            sym_valid = 1'b0;
            repeat (gap) cycle();
        end
        sym_valid  = 1'b1;
        sym_type   = 2'(t);
        sym_nibble = 4'(nib);
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 1200) begin
            cycle();
            n++;
        end
        checks++;
        assert (last_acc) else begin
            failures++;
            $error("FAIL accept_timeout t=%0t observed=not_accepted expected=accepted", $time);
        end
    endtask

    task automatic wait_idle();
        int n;
        sym_valid = 1'b0;
        n = 0;
        while ((m_active || q.size() > 0) && n < 2000) begin
            cycle();
            n++;
        end
        repeat (2) cycle();
        checks++;
        assert (!m_active && q.size() == 0 && busy === 1'b0) else begin
            failures++;
            $error("FAIL idle_timeout t=%0t observed=busy%b expected=idle", $time, busy);
        end
    endtask

    task automatic frame(input int nibs[$], input int gap_max);
        send(0, 0, $urandom_range(0, gap_max));
        foreach (nibs[i]) send(1, nibs[i], $urandom_range(0, gap_max));
        send(2, 0, $urandom_range(0, gap_max));
    endtask

    initial begin
        int nibs[$];
        int n;
        reset_tx_n  = 1'b0;
        fixed_frame = 1'b1;
        pause_len   = '0;
        sym_valid   = 1'b0;
        sym_type    = 2'd0;
        sym_nibble  = 4'd0;

        // Reset values
        repeat (2) @(posedge ticks);
        #1;
        chk("rst_data_pulse", data_pulse, 1'b1);
        chk("rst_sym_ready",  sym_ready,  1'b1);
        chk("rst_busy",       busy,       1'b0);
        chk("rst_pulse_done", pulse_done, 1'b0);
        chk("rst_overrun",    frame_overrun, 1'b0);
        chk("rst_illegal",    illegal_sym,   1'b0);
        reset_tx_n = 1'b1;
        repeat (2) cycle();

        // SYNC then PAUSE, fixed frame: 56 + 226
        send(0, 0, 0);
        send(2, 0, 0);
        wait_idle();

        // Two frames of SYNC + nibbles 0..7 + PAUSE, valid held high throughout
        nibs = '{0, 1, 2, 3, 4, 5, 6, 7};
        frame(nibs, 0);
        frame(nibs, 0);
        wait_idle();

        // Overrun: 56 + 8*27 = 272 -> remaining 10 < 12, clamp
        nibs = '{15, 15, 15, 15, 15, 15, 15, 15};
        frame(nibs, 0);
        wait_idle();
        // acc beyond frame: 56 + 9*27 = 299 >= 282
        nibs = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
        frame(nibs, 0);
        wait_idle();

        // Randomized frames with random gaps between commands
        repeat (4) begin
            nibs.delete();
            n = $urandom_range(1, 8);
            repeat (n) nibs.push_back($urandom_range(0, 15));
            frame(nibs, 3);
        end
        wait_idle();

        // Free-running PAUSE length
        fixed_frame = 1'b0;
        pause_len = CNT_W'(5);
        send(0, 0, 0);
        send(2, 0, 0);
        wait_idle();
        pause_len = CNT_W'(300);
        send(2, 0, 0);
        wait_idle();
        repeat (3) begin
            pause_len = CNT_W'($urandom_range(0, 400));
            send(1, $urandom_range(0, 15), $urandom_range(0, 2));
            send(2, 0, 0);
            wait_idle();
        end

        // Reserved type: strobe only, line stays idle
        send(3, 0, 0);
        wait_idle();
        // Reserved squeezed between real symbols
        send(0, 0, 0);
        send(3, 0, 0);
        send(1, 9, 0);
        wait_idle();

        // Asynchronous reset at tick 20 of a SYNC
        fixed_frame = 1'b1;
        send(0, 0, 0);
        sym_valid = 1'b0;
        n = 0;
        while (!(m_active && m_pos == 20) && n < 200) begin
            cycle();
            n++;
        end
        reset_tx_n = 1'b0;
        #1;
        chk("async_rst_data_pulse", data_pulse, 1'b1);
        chk("async_rst_busy",       busy,       1'b0);
        chk("async_rst_sym_ready",  sym_ready,  1'b1);
        chk("async_rst_pulse_done", pulse_done, 1'b0);
        q.delete();
        m_active = 1'b0;
        m_pos = 0;
        m_acc = 0;
        m_ill = 1'b0;
        repeat (2) cycle();
        reset_tx_n = 1'b1;
        // Fresh SYNC + PAUSE after release: PAUSE must be 282 - 56
        send(0, 0, 0);
        send(2, 0, 0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
